// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-stage branch predictor. A direct-mapped branch target buffer holds,
// per entry, a valid bit, the upper PC bits as a tag, a full 32-bit target and
// a 2-bit saturating direction counter. Fetch looks up the table and gets a
// registered prediction one cycle later. The EXE-stage resolver trains the
// table through the update port.
//
// Ports
//   clk               rising-edge clock
//   resetn            asynchronous active-low reset
//   fs_req_valid      fetch lookup request this cycle
//   fs_pc[31:0]       PC being fetched
//   flush             pipeline flush; kills the lookup issued this cycle
//   bp_valid          prediction valid (one cycle after the request)
//   predict_is_taken  predicted taken
//   predict_target    predicted target; 0 when predicted not taken
//   es_upd_valid      resolved branch/jump from EXE
//   es_upd_pc[31:0]   PC of the resolved branch/jump
//   es_upd_taken      actual direction
//   es_upd_target     actual target
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_req_valid,
  input  logic [31:0] fs_pc,
  input  logic        flush,
  output logic        bp_valid,
  output logic        predict_is_taken,
  output logic [31:0] predict_target,
  input  logic        es_upd_valid,
  input  logic [31:0] es_upd_pc,
  input  logic        es_upd_taken,
  input  logic [31:0] es_upd_target
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_T = 2'b10;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fs_pc[1:0], es_upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup path (reads pre-update state; no bypass from the update port)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic             rd_taken;

  assign rd_idx   = fs_pc[IDX_W+1:2];
  assign rd_tag   = fs_pc[31:IDX_W+2];
  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken = rd_hit && ctr_q[rd_idx][1];

  logic        bp_valid_q, bp_valid_d;
  logic        taken_q,    taken_d;
  logic [31:0] target_q,   target_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bp_valid_d = 1'b0;
    taken_d    = 1'b0;
    target_d   = target_q;   // target is don't-care when no result; hold it
    if (fs_req_valid && !flush) begin
      bp_valid_d = 1'b1;
      taken_d    = rd_taken;
      target_d   = rd_taken ? tgt_q[rd_idx] : 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bp_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= 32'd0;
    end else begin
      bp_valid_q <= bp_valid_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
    end
  end

  assign bp_valid         = bp_valid_q;
  assign predict_is_taken = taken_q;
  assign predict_target   = target_q;

  // ---------------------------------------------------------------------------
  // Update path (flush never gates training)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_train;   // existing entry: move counter
  logic             up_alloc;   // taken miss: (re)allocate the slot

  assign up_idx   = es_upd_pc[IDX_W+1:2];
  assign up_tag   = es_upd_pc[31:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_train = es_upd_valid && up_hit;
  assign up_alloc = es_upd_valid && !up_hit && es_upd_taken;

  // Only the valid bits are reset; an invalid entry's payload is never used.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (up_alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // NOTE: the tag/target/counter arrays carry no reset; they are qualified by
  // valid_q, and leaving them unreset lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (up_train) begin
      if (es_upd_taken) begin
        ctr_q[up_idx] <= sat_inc(ctr_q[up_idx]);
        tgt_q[up_idx] <= es_upd_target;
      end else begin
        ctr_q[up_idx] <= sat_dec(ctr_q[up_idx]);
      end
    end else if (up_alloc) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= es_upd_target;
      ctr_q[up_idx] <= CTR_WEAK_T;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed plus randomized stimulus for branch_predictor. The reference model
// keeps, per slot, the full PC last installed there, its target and a 0..3
// confidence level, and predicts from those with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fs_req_valid = 1'b0;
  logic [31:0] fs_pc = '0;
  logic        flush = 1'b0;
  logic        bp_valid;
  logic        predict_is_taken;
  logic [31:0] predict_target;
  logic        es_upd_valid = 1'b0;
  logic [31:0] es_upd_pc = '0;
  logic        es_upd_taken = 1'b0;
  logic [31:0] es_upd_target = '0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .fs_req_valid     (fs_req_valid),
    .fs_pc            (fs_pc),
    .flush            (flush),
    .bp_valid         (bp_valid),
    .predict_is_taken (predict_is_taken),
    .predict_target   (predict_target),
    .es_upd_valid     (es_upd_valid),
    .es_upd_pc        (es_upd_pc),
    .es_upd_taken     (es_upd_taken),
    .es_upd_target    (es_upd_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: slot -> {installed?, full PC, target, confidence 0..3}
  // ---------------------------------------------------------------------------
  bit          m_v   [ENTRIES];
  logic [31:0] m_pc  [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // Same slot and same word address means the same branch.
  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot_of(pc);
    return m_v[s] && ((m_pc[s] >> 2) == (pc >> 2));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
  endtask

  task automatic m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    int s = slot_of(pc);
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        m_tgt[s] = tgt;
      end else begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (taken) begin
      m_v[s]   = 1'b1;
      m_pc[s]  = pc;
      m_tgt[s] = tgt;
      m_ctr[s] = 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict from the pre-update model, train the
  // model, then sample outputs 1 time unit after the edge.
  task automatic cycle(input bit req, input logic [31:0] pc, input bit fl,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input string tag);
    bit          e_valid, e_taken;
    logic [31:0] e_tgt;
    fs_req_valid  = req;
    fs_pc         = pc;
    flush         = fl;
    es_upd_valid  = uv;
    es_upd_pc     = upc;
    es_upd_taken  = ut;
    es_upd_target = utgt;
    e_valid = req && !fl;
    e_taken = e_valid && m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
    e_tgt   = e_taken ? m_tgt[slot_of(pc)] : 32'd0;
    if (uv) m_update(upc, ut, utgt);
    @(posedge clk);
    #1;
    check({tag, ".bp_valid"}, {31'd0, bp_valid}, {31'd0, e_valid});
    check({tag, ".taken"}, {31'd0, predict_is_taken}, {31'd0, e_taken});
    if (e_valid) check({tag, ".target"}, predict_target, e_tgt);
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag);
    cycle(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, tag);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input string tag);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, pc, t, tgt, tag);
  endtask

  // Mid-cycle async reset; whatever was being presented is dropped.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    fs_req_valid = 1'b0;
    es_upd_valid = 1'b0;
    flush = 1'b0;
    m_clear();
    #1;
    check({tag, ".bp_valid"}, {31'd0, bp_valid}, 32'd0);
    check({tag, ".taken"}, {31'd0, predict_is_taken}, 32'd0);
    check({tag, ".target"}, predict_target, 32'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  logic [31:0] bases [4] = '{32'h0040_0000, 32'h0040_0400, 32'hBFC0_0000, 32'h8000_1000};
  logic [31:0] seen [$];

  initial begin
    logic [31:0] pc, upc, tgt;
    bit req, fl, uv, ut;

    m_clear();
    // Power-on reset
    #3;
    check("por.bp_valid", {31'd0, bp_valid}, 32'd0);
    check("por.taken", {31'd0, predict_is_taken}, 32'd0);
    check("por.target", predict_target, 32'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;

    // Cold lookup, allocation, first hit
    lookup(32'hBFC0_0010, "cold");
    update(32'hBFC0_0010, 1'b1, 32'hBFC0_0100, "alloc");
    lookup(32'hBFC0_0010, "hit_weak_t");

    // Not-taken training down to and past strong-NT (lookup rides along)
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hBFC0_0010, 1'b0, 1'b1, 32'hBFC0_0010, 1'b0, 32'hDEAD_BEEF, "nt_train");
    lookup(32'hBFC0_0010, "after_nt");
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'hBFC0_0010, 1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0200, "t_train");
    lookup(32'hBFC0_0010, "after_t");
    // Push to strong-T and beyond, then one NT keeps it taken
    for (int i = 0; i < 3; i++) update(32'hBFC0_0010, 1'b1, 32'hBFC0_0300, "t_sat");
    update(32'hBFC0_0010, 1'b0, 32'd0, "nt_from_sat");
    lookup(32'hBFC0_0010, "after_sat");

    // Aliasing at index 0
    update(32'h0040_0040, 1'b1, 32'h0040_0200, "alias_a");
    lookup(32'h0040_0040, "alias_a_hit");
    update(32'h0040_0440, 1'b0, 32'h0, "alias_b_nt_miss");
    lookup(32'h0040_0040, "alias_a_kept");
    update(32'h0040_0440, 1'b1, 32'h0040_0300, "alias_b");
    lookup(32'h0040_0040, "alias_a_evicted");
    lookup(32'h0040_0440, "alias_b_hit");

    // Same-cycle lookup and update on an empty slot: no bypass
    cycle(1'b1, 32'h0040_0058, 1'b0, 1'b1, 32'h0040_0058, 1'b1, 32'h1234_5678, "same_cyc");
    lookup(32'h0040_0058, "same_cyc_next");

    // Flush kills the lookup but not the update
    cycle(1'b1, 32'h0040_0058, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, "flush");
    cycle(1'b1, 32'h8000_103C, 1'b1, 1'b1, 32'h8000_103C, 1'b1, 32'h8000_2000, "flush_upd");
    lookup(32'h8000_103C, "flush_upd_hit");
    cycle(1'b0, 32'h8000_103C, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "idle");

    // Randomized traffic over a few aliasing PC regions
    for (int n = 0; n < 1500; n++) begin
      pc  = bases[$urandom_range(3)] | ($urandom_range(ENTRIES - 1) << 2) | $urandom_range(3);
      upc = bases[$urandom_range(3)] | ($urandom_range(ENTRIES - 1) << 2) | $urandom_range(3);
      if ($urandom_range(3) == 0) upc = pc;
      tgt = $urandom;
      req = ($urandom_range(3) != 0);
      fl  = ($urandom_range(9) == 0);
      uv  = ($urandom_range(1) == 0);
      ut  = ($urandom_range(2) != 0);
      cycle(req, pc, fl, uv, upc, ut, tgt, "rand");
    end

    // Remember installed PCs, drive a pending taken update and lookup, then
    // reset mid-cycle: nothing survives.
    for (int i = 0; i < ENTRIES; i++) if (m_v[i]) seen.push_back(m_pc[i]);
    seen.push_back(32'h0040_0080);
    fs_req_valid  = 1'b1;
    fs_pc         = 32'hBFC0_0010;
    es_upd_valid  = 1'b1;
    es_upd_pc     = 32'h0040_0080;
    es_upd_taken  = 1'b1;
    es_upd_target = 32'h0040_0900;
    pulse_reset("mid_reset");
    foreach (seen[i]) lookup(seen[i], "post_reset_miss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
